// File: rtl/mem_stage_pkg.sv
// Shared memory-map and sizing constants for the memory stage.
// Also provides the I/O address decoder used by mem_stage.
package mem_stage_pkg;

    localparam int DBITS         = 32;
    localparam int DMEMADDRBITS  = 13;
    localparam int DMEMWORDBITS  = 2;
    localparam int DMEMWORDS     = 2048;
    localparam int DMEMINDEXBITS = DMEMADDRBITS - DMEMWORDBITS;

    localparam logic [DBITS-1:0] ADDR_HEX  = 32'hF0000000;
    localparam logic [DBITS-1:0] ADDR_LEDR = 32'hF0000004;
    localparam logic [DBITS-1:0] ADDR_LEDG = 32'hF0000008;
    localparam logic [DBITS-1:0] ADDR_KEY  = 32'hF0000010;
    localparam logic [DBITS-1:0] ADDR_SW   = 32'hF0000014;

    typedef enum logic [2:0] {
        IO_NONE,
        IO_HEX,
        IO_LEDR,
        IO_LEDG,
        IO_KEY,
        IO_SW
    } ioSel_e;

    // I/O registers respond only to an exact address match.
    function automatic ioSel_e decodeIo(input logic [DBITS-1:0] a);
        ioSel_e sel;
        sel = IO_NONE;
        case (a)
            ADDR_HEX:  sel = IO_HEX;
            ADDR_LEDR: sel = IO_LEDR;
            ADDR_LEDG: sel = IO_LEDG;
            ADDR_KEY:  sel = IO_KEY;
            ADDR_SW:   sel = IO_SW;
            default:   sel = IO_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mem_stage_dmem_ram.sv
// Single-port data RAM with synchronous write and registered read.
// The read register only updates on a read so its value is held otherwise.
module dmem_ram
    import mem_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic [DMEMINDEXBITS-1:0] i_addr,
    input  logic [DBITS-1:0]         i_wdata,
    output logic [DBITS-1:0]         o_rdata
);

    logic [DBITS-1:0] r_mem [DMEMWORDS];
    logic [DBITS-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: data RAM, HEX/LEDR/LEDG/KEY/SW I/O and one-cycle load response.
// Define IO_SYNC_EN to add two-flop synchronizers on key_in and sw_in.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic             is_lw,
    input  logic             is_sw,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wdata,
    input  logic [3:0]       key_in,
    input  logic [9:0]       sw_in,
    output logic [DBITS-1:0] load_data,
    output logic             load_valid,
    output logic             addr_err,
    output logic [15:0]      hex_out,
    output logic [9:0]       ledr_out,
    output logic [7:0]       ledg_out
);

    logic             w_ramHit;
    ioSel_e           w_ioSel;
    logic             w_legal;
    logic             w_ramWe;
    logic             w_ramRe;
    logic [DBITS-1:0] w_ramData;
    logic [DBITS-1:0] w_ioRdata;
    logic [3:0]       w_key;
    logic [9:0]       w_sw;

    logic [15:0]      r_hex;
    logic [9:0]       r_ledr;
    logic [7:0]       r_ledg;
    logic             r_loadValid;
    logic             r_addrErr;
    logic             r_selRam;
    logic [DBITS-1:0] r_ioData;

    assign w_ramHit = (addr[DBITS-1:DMEMADDRBITS] == '0);
    assign w_ioSel  = decodeIo(addr);
    assign w_legal  = valid_in && (is_lw ^ is_sw) && (addr[1:0] == 2'b00) &&
                      (w_ramHit || (w_ioSel != IO_NONE));
    assign w_ramWe  = w_legal && is_sw && w_ramHit;
    assign w_ramRe  = w_legal && is_lw && w_ramHit;

`ifdef IO_SYNC_EN
    logic [3:0] r_keyMeta, r_keySync;
    logic [9:0] r_swMeta, r_swSync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_keyMeta <= '0;
            r_keySync <= '0;
            r_swMeta  <= '0;
            r_swSync  <= '0;
        end else begin
            r_keyMeta <= key_in;
            r_keySync <= r_keyMeta;
            r_swMeta  <= sw_in;
            r_swSync  <= r_swMeta;
        end
    end

    assign w_key = r_keySync;
    assign w_sw  = r_swSync;
`else
    assign w_key = key_in;
    assign w_sw  = sw_in;
`endif

    dmem_ram u_dmem (
        .clk     (clk),
        .i_we    (w_ramWe),
        .i_re    (w_ramRe),
        .i_addr  (addr[DMEMADDRBITS-1:DMEMWORDBITS]),
        .i_wdata (wdata),
        .o_rdata (w_ramData)
    );

    always_comb begin
        w_ioRdata = '0;
        case (w_ioSel)
            IO_HEX:  w_ioRdata = {{(DBITS-16){1'b0}}, r_hex};
            IO_LEDR: w_ioRdata = {{(DBITS-10){1'b0}}, r_ledr};
            IO_LEDG: w_ioRdata = {{(DBITS-8){1'b0}}, r_ledg};
            IO_KEY:  w_ioRdata = {{(DBITS-4){1'b0}}, w_key};
            IO_SW:   w_ioRdata = {{(DBITS-10){1'b0}}, w_sw};
            default: w_ioRdata = '0;
        endcase
    end

    // KEY and SW are read-only, so stores to them fall through silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hex  <= '0;
            r_ledr <= '0;
            r_ledg <= '0;
        end else if (w_legal && is_sw) begin
            case (w_ioSel)
                IO_HEX:  r_hex  <= wdata[15:0];
                IO_LEDR: r_ledr <= wdata[9:0];
                IO_LEDG: r_ledg <= wdata[7:0];
                default: ;
            endcase
        end
    end

    // Every load gets a response, so an illegal load returns zero instead of stalling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_loadValid <= 1'b0;
            r_addrErr   <= 1'b0;
            r_selRam    <= 1'b0;
            r_ioData    <= '0;
        end else begin
            r_loadValid <= valid_in && is_lw;
            r_addrErr   <= valid_in && !w_legal;
            if (valid_in && is_lw) begin
                r_selRam <= w_ramRe;
                r_ioData <= w_legal ? w_ioRdata : '0;
            end
        end
    end

    assign load_data  = r_selRam ? w_ramData : r_ioData;
    assign load_valid = r_loadValid;
    assign addr_err   = r_addrErr;
    assign hex_out    = r_hex;
    assign ledr_out   = r_ledr;
    assign ledg_out   = r_ledg;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard testbench for mem_stage; expectations follow IO_SYNC_EN when defined.
// Each op pushes its expected response, popped and compared one cycle later.
module tb_mem_stage;

    localparam logic [31:0] A_HEX  = 32'hF0000000;
    localparam logic [31:0] A_LEDR = 32'hF0000004;
    localparam logic [31:0] A_LEDG = 32'hF0000008;
    localparam logic [31:0] A_KEY  = 32'hF0000010;
    localparam logic [31:0] A_SW   = 32'hF0000014;

    typedef struct packed {
        logic        v;
        logic        lw;
        logic        sw;
        logic [31:0] a;
        logic [31:0] wd;
        logic        eV;
        logic [31:0] eD;
        logic        eC;
        logic        eE;
    } op_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic        chkData;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic        is_lw = 1'b0;
    logic        is_sw = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  key_in = '0;
    logic [9:0]  sw_in = '0;
    logic [31:0] load_data;
    logic        load_valid;
    logic        addr_err;
    logic [15:0] hex_out;
    logic [9:0]  ledr_out;
    logic [7:0]  ledg_out;

    int   checks = 0;
    int   errors = 0;
    exp_t sbQ[$];

    mem_stage dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .is_lw      (is_lw),
        .is_sw      (is_sw),
        .addr       (addr),
        .wdata      (wdata),
        .key_in     (key_in),
        .sw_in      (sw_in),
        .load_data  (load_data),
        .load_valid (load_valid),
        .addr_err   (addr_err),
        .hex_out    (hex_out),
        .ledr_out   (ledr_out),
        .ledg_out   (ledg_out)
    );

    always #5 clk = ~clk;

    function automatic op_t mkOp(input logic v, lw, sw, input logic [31:0] a, wd,
                                 input logic eV, input logic [31:0] eD, input logic eC, eE);
        op_t o;
        o.v = v; o.lw = lw; o.sw = sw; o.a = a; o.wd = wd;
        o.eV = eV; o.eD = eD; o.eC = eC; o.eE = eE;
        return o;
    endfunction

    function automatic op_t ld(input logic [31:0] a, input logic [31:0] d);
        return mkOp(1'b1, 1'b1, 1'b0, a, 32'h0, 1'b1, d, 1'b1, 1'b0);
    endfunction

    function automatic op_t st(input logic [31:0] a, input logic [31:0] d);
        return mkOp(1'b1, 1'b0, 1'b1, a, d, 1'b0, 32'h0, 1'b0, 1'b0);
    endfunction

    function automatic op_t idle();
        return mkOp(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endfunction

    // Drives one op for one cycle and records the response expected in the next cycle.
    task automatic issue(input op_t o);
        exp_t e;
        valid_in = o.v;
        is_lw    = o.lw;
        is_sw    = o.sw;
        addr     = o.a;
        wdata    = o.wd;
        e.valid   = o.eV;
        e.data    = o.eD;
        e.chkData = o.eC;
        e.err     = o.eE;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic goIdle();
        valid_in = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
    endtask

    task automatic test_reset();
        #7;
        checks++; if (load_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %0b want 0", load_valid); end
        checks++; if (load_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_data got %h want 0", load_data); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err got %0b want 0", addr_err); end
        checks++; if (hex_out !== 16'h0) begin errors++; $display("[TB] FAIL rst_hex got %h want 0", hex_out); end
        checks++; if (ledr_out !== 10'h0) begin errors++; $display("[TB] FAIL rst_ledr got %h want 0", ledr_out); end
        checks++; if (ledg_out !== 8'h0) begin errors++; $display("[TB] FAIL rst_ledg got %h want 0", ledg_out); end
        @(posedge clk); #1;
        reset = 1'b0;
        valid_in = 1'b1; is_sw = 1'b1; is_lw = 1'b0; addr = A_HEX; wdata = 32'h55AA;
        @(posedge clk); #1;
        is_sw = 1'b0; is_lw = 1'b1;
        @(posedge clk); #1;
        goIdle();
        checks++; if (load_valid !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_valid got %0b want 1", load_valid); end
        checks++; if (hex_out !== 16'h55AA) begin errors++; $display("[TB] FAIL pre_rst_hex got %h want 55aa", hex_out); end
        valid_in = 1'b1; is_lw = 1'b1; addr = A_HEX;
        #2 reset = 1'b1;
        #1;
        checks++; if (load_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %0b want 0", load_valid); end
        checks++; if (load_data !== 32'h0) begin errors++; $display("[TB] FAIL midrst_data got %h want 0", load_data); end
        checks++; if (hex_out !== 16'h0) begin errors++; $display("[TB] FAIL midrst_hex got %h want 0", hex_out); end
        goIdle();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (load_valid !== 1'b0) begin errors++; $display("[TB] FAIL postrst_valid got %0b want 0", load_valid); end
    endtask

    task automatic test_ram();
        op_t  ops[$];
        exp_t e;
        ops.push_back(st(32'h100, 32'hDEADBEEF));
        ops.push_back(ld(32'h100, 32'hDEADBEEF));
        ops.push_back(st(32'h1FFC, 32'h13579BDF));
        ops.push_back(idle());
        ops.push_back(ld(32'h1FFC, 32'h13579BDF));
        ops.push_back(mkOp(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h13579BDF, 1'b1, 1'b0));
        ops.push_back(mkOp(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h13579BDF, 1'b1, 1'b0));
        foreach (ops[i]) begin
            issue(ops[i]);
            e = sbQ.pop_front();
            checks++; if (load_valid !== e.valid) begin errors++; $display("[TB] FAIL ram[%0d] valid got %0b want %0b", i, load_valid, e.valid); end
            if (e.chkData) begin
                checks++; if (load_data !== e.data) begin errors++; $display("[TB] FAIL ram[%0d] data got %h want %h", i, load_data, e.data); end
            end
            checks++; if (addr_err !== e.err) begin errors++; $display("[TB] FAIL ram[%0d] err got %0b want %0b", i, addr_err, e.err); end
        end
        goIdle();
    endtask

    task automatic test_io();
        op_t  ops[$];
        exp_t e;
        ops.push_back(st(A_HEX, 32'h00012345));
        ops.push_back(st(A_LEDR, 32'h000003FF));
        ops.push_back(st(A_LEDG, 32'hABCDEF12));
        ops.push_back(st(A_KEY, 32'hFFFFFFFF));
        ops.push_back(st(A_SW, 32'hFFFFFFFF));
        ops.push_back(ld(A_HEX, 32'h2345));
        ops.push_back(ld(A_LEDR, 32'h3FF));
        ops.push_back(ld(A_LEDG, 32'h12));
        foreach (ops[i]) begin
            issue(ops[i]);
            e = sbQ.pop_front();
            checks++; if (load_valid !== e.valid) begin errors++; $display("[TB] FAIL io[%0d] valid got %0b want %0b", i, load_valid, e.valid); end
            if (e.chkData) begin
                checks++; if (load_data !== e.data) begin errors++; $display("[TB] FAIL io[%0d] data got %h want %h", i, load_data, e.data); end
            end
            checks++; if (addr_err !== e.err) begin errors++; $display("[TB] FAIL io[%0d] err got %0b want %0b", i, addr_err, e.err); end
        end
        goIdle();
        checks++; if (hex_out !== 16'h2345) begin errors++; $display("[TB] FAIL io_hex got %h want 2345", hex_out); end
        checks++; if (ledr_out !== 10'h3FF) begin errors++; $display("[TB] FAIL io_ledr got %h want 3ff", ledr_out); end
        checks++; if (ledg_out !== 8'h12) begin errors++; $display("[TB] FAIL io_ledg got %h want 12", ledg_out); end
    endtask

    task automatic test_inputs();
        op_t  ops[$];
        exp_t e;
        logic [31:0] staleSw;
`ifdef IO_SYNC_EN
        staleSw = 32'h155;
`else
        staleSw = 32'h2AA;
`endif
        key_in = 4'b1010;
        sw_in  = 10'h155;
        ops.push_back(idle());
        ops.push_back(idle());
        ops.push_back(idle());
        ops.push_back(ld(A_KEY, 32'hA));
        ops.push_back(ld(A_SW, 32'h155));
        ops.push_back(idle());
        ops.push_back(ld(A_SW, staleSw));
        ops.push_back(ld(A_SW, 32'h2AA));
        foreach (ops[i]) begin
            if (i == 5) sw_in = 10'h2AA;
            issue(ops[i]);
            e = sbQ.pop_front();
            checks++; if (load_valid !== e.valid) begin errors++; $display("[TB] FAIL in[%0d] valid got %0b want %0b", i, load_valid, e.valid); end
            if (e.chkData) begin
                checks++; if (load_data !== e.data) begin errors++; $display("[TB] FAIL in[%0d] data got %h want %h", i, load_data, e.data); end
            end
            checks++; if (addr_err !== e.err) begin errors++; $display("[TB] FAIL in[%0d] err got %0b want %0b", i, addr_err, e.err); end
        end
        goIdle();
    endtask

    task automatic test_errors();
        op_t  ops[$];
        exp_t e;
        ops.push_back(st(32'h0, 32'h11111111));
        ops.push_back(st(32'h4, 32'h44444444));
        ops.push_back(mkOp(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1));
        ops.push_back(mkOp(1'b1, 1'b0, 1'b1, 32'h2000, 32'hBAD0BAD0, 1'b0, 32'h0, 1'b0, 1'b1));
        ops.push_back(ld(32'h0, 32'h11111111));
        ops.push_back(mkOp(1'b1, 1'b1, 1'b1, 32'h4, 32'h77777777, 1'b1, 32'h0, 1'b1, 1'b1));
        ops.push_back(ld(32'h4, 32'h44444444));
        ops.push_back(mkOp(1'b1, 1'b1, 1'b0, 32'hF000000C, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1));
        ops.push_back(mkOp(1'b1, 1'b0, 1'b1, 32'hF0000002, 32'hFFFF, 1'b0, 32'h0, 1'b0, 1'b1));
        ops.push_back(mkOp(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1));
        ops.push_back(mkOp(1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0));
        foreach (ops[i]) begin
            issue(ops[i]);
            e = sbQ.pop_front();
            checks++; if (load_valid !== e.valid) begin errors++; $display("[TB] FAIL err[%0d] valid got %0b want %0b", i, load_valid, e.valid); end
            if (e.chkData) begin
                checks++; if (load_data !== e.data) begin errors++; $display("[TB] FAIL err[%0d] data got %h want %h", i, load_data, e.data); end
            end
            checks++; if (addr_err !== e.err) begin errors++; $display("[TB] FAIL err[%0d] err got %0b want %0b", i, addr_err, e.err); end
        end
        goIdle();
        checks++; if (hex_out !== 16'h2345) begin errors++; $display("[TB] FAIL err_hex got %h want 2345", hex_out); end
    endtask

    task automatic test_back_to_back();
        op_t         ops[$];
        exp_t        e;
        logic [31:0] model [16];
        int          order [16];
        ops.push_back(st(32'h0, 32'hA0A0A0A0));
        ops.push_back(st(32'h4, 32'hA4A4A4A4));
        ops.push_back(st(32'h8, 32'hA8A8A8A8));
        ops.push_back(ld(32'h0, 32'hA0A0A0A0));
        ops.push_back(ld(32'h4, 32'hA4A4A4A4));
        ops.push_back(ld(32'h8, 32'hA8A8A8A8));
        ops.push_back(st(32'h8, 32'hCAFEF00D));
        ops.push_back(ld(32'h8, 32'hCAFEF00D));
        for (int k = 0; k < 16; k++) begin
            model[k] = $urandom;
            order[k] = k;
            ops.push_back(st(32'h400 + 32'(k * 4), model[k]));
        end
        for (int k = 15; k > 0; k--) begin
            int j;
            int t;
            j = $urandom_range(k, 0);
            t = order[k]; order[k] = order[j]; order[j] = t;
        end
        for (int k = 0; k < 16; k++) begin
            ops.push_back(ld(32'h400 + 32'(order[k] * 4), model[order[k]]));
        end
        foreach (ops[i]) begin
            issue(ops[i]);
            e = sbQ.pop_front();
            checks++; if (load_valid !== e.valid) begin errors++; $display("[TB] FAIL b2b[%0d] valid got %0b want %0b", i, load_valid, e.valid); end
            if (e.chkData) begin
                checks++; if (load_data !== e.data) begin errors++; $display("[TB] FAIL b2b[%0d] data got %h want %h", i, load_data, e.data); end
            end
            checks++; if (addr_err !== e.err) begin errors++; $display("[TB] FAIL b2b[%0d] err got %0b want %0b", i, addr_err, e.err); end
        end
        goIdle();
    endtask

    initial begin
        test_reset();
        test_ram();
        test_io();
        test_inputs();
        test_errors();
        test_back_to_back();
        checks++; if (sbQ.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_leftover got %0d want 0", sbQ.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
